// File: rtl/dm_ctrl_if.sv
// Bus bundle for dm_ctrl: CPU load/store port, debug/loader port and the word-wide memory port.
// The slave modport is the controller's view; the master modport is the requester/memory side.
interface dm_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_sext;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_din, mem_we,
        input  mem_dout,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_din, mem_we,
        output mem_dout,
        input  busy
    );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory access controller: round-robin CPU/debug arbitration, sub-word loads by lane
// extraction, sub-word stores by read-modify-write on a word-only memory.
module dm_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    dm_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_RMW_RD, S_ACCESS, S_ACK, S_ERR} state_t;

    state_t            r_state, w_next;
    logic              r_grant_dbg;   // current grant, doubles as last_grant for round-robin
    logic              r_we, r_sext;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_merge, r_rdata;

    logic              w_cpu_win, w_dbg_win, w_misalign, w_sub_store;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load, w_store;

    // CPU wins when alone or when the debug port was served last.
    always_comb begin
        w_cpu_win   = bus.cpu_req && (!bus.dbg_req || r_grant_dbg);
        w_dbg_win   = bus.dbg_req && !w_cpu_win;
        w_misalign  = w_cpu_win &&
                      ((bus.cpu_size == 2'b01 && bus.cpu_addr[0]) ||
                       (bus.cpu_size[1] && bus.cpu_addr[1:0] != 2'b00));
        w_sub_store = w_cpu_win && bus.cpu_we && !bus.cpu_size[1];
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_misalign)                  w_next = S_ERR;
                else if (w_sub_store)            w_next = S_RMW_RD;
                else if (w_cpu_win || w_dbg_win) w_next = S_ACCESS;
            end
            S_RMW_RD: w_next = S_ACCESS;
            S_ACCESS: w_next = S_ACK;
            S_ACK:    w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_byte = 8'(bus.mem_dout >> {r_addr[1:0], 3'b000});
        w_half = r_addr[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = bus.mem_dout;
        endcase
        w_store = r_merge;
        case (r_size)
            2'b00:   w_store[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   w_store[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
            default: w_store = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_dbg <= 1'b1;
            r_we        <= 1'b0;
            r_sext      <= 1'b0;
            r_size      <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_merge     <= '0;
            r_rdata     <= '0;
        end else begin
            if (r_state == S_IDLE && (w_cpu_win || w_dbg_win)) begin
                r_grant_dbg <= w_dbg_win;
                if (w_dbg_win) begin
                    r_we    <= bus.dbg_we;
                    r_size  <= 2'b10;
                    r_sext  <= 1'b0;
                    r_addr  <= bus.dbg_addr;
                    r_wdata <= bus.dbg_wdata;
                end else begin
                    r_we    <= bus.cpu_we;
                    r_size  <= bus.cpu_size;
                    r_sext  <= bus.cpu_sext;
                    r_addr  <= bus.cpu_addr;
                    r_wdata <= bus.cpu_wdata;
                end
            end
            if (r_state == S_RMW_RD) r_merge <= bus.mem_dout;
            if (r_state == S_ACCESS) r_rdata <= r_we ? 32'h0 : w_load;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_err   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_rdata = '0;
        bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_RMW_RD: bus.mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            S_ACCESS: begin
                bus.mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
                if (r_we) begin
                    bus.mem_we  = 1'b1;
                    bus.mem_din = w_store;
                end
            end
            S_ACK: begin
                if (r_grant_dbg) begin
                    bus.dbg_ack   = 1'b1;
                    bus.dbg_rdata = r_rdata;
                end else begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_rdata = r_rdata;
                end
            end
            S_ERR: begin
                bus.cpu_ack = 1'b1;
                bus.cpu_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus random traffic scored against a
// byte-array reference model of the memory.
module tb_dm_ctrl;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    dm_ctrl #(.ADDR_W(ADDR_W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:255];
    int          we_cnt;
    assign bus.mem_dout = mem[bus.mem_addr[9:2]];

    always begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        we_cnt = 0;
        forever begin
            @(posedge clk);
            if (bus.mem_we) begin
                mem[bus.mem_addr[9:2]] = bus.mem_din;
                we_cnt = we_cnt + 1;
            end
        end
    end

    logic [7:0] ref_mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v |= 32'(ref_mem[(a & ~3) + i]) << (8 * i);
        return v;
    endfunction

    task automatic ref_cpu(input logic we, input logic [1:0] size, input logic sext,
                           input int addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        int n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        logic [31:0] v = 0;
        err = (addr % n) != 0;
        rdata = 0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            lat = (n < 4) ? 3 : 2;
        end else begin
            for (int i = 0; i < n; i++) v |= 32'(ref_mem[addr + i]) << (8 * i);
            if (sext && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
            rdata = v;
            lat = 2;
        end
    endtask

    task automatic cpu_xfer(input logic we, input logic [1:0] size, input logic sext,
                            input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat,
                            output logic other);
        @(negedge clk);
        bus.cpu_we = we; bus.cpu_size = size; bus.cpu_sext = sext;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        lat = 0; other = 1'b0; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.dbg_ack) other = 1'b1;
            if (bus.cpu_ack) begin
                lat = c; rdata = bus.cpu_rdata; err = bus.cpu_err;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic dbg_xfer(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output logic other);
        @(negedge clk);
        bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
        lat = 0; other = 1'b0; rdata = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.cpu_ack) other = 1'b1;
            if (bus.dbg_ack) begin
                lat = c; rdata = bus.dbg_rdata;
                break;
            end
        end
        bus.dbg_req = 1'b0;
    endtask

    task automatic cpu_op(input string tag, input logic we, input logic [1:0] size,
                          input logic sext, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        logic [31:0] er, r;
        logic ee, e, oth;
        int el, l;
        ref_cpu(we, size, sext, int'(addr), wdata, er, ee, el);
        cpu_xfer(we, size, sext, addr, wdata, r, e, l, oth);
        check({tag, ".rdata"}, r, er);
        check({tag, ".err"}, {31'b0, e}, {31'b0, ee});
        check({tag, ".lat"}, 32'(l), 32'(el));
        check({tag, ".dbg_ack"}, {31'b0, oth}, 32'h0);
        rdata = r;
    endtask

    task automatic dbg_op(input string tag, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        logic [31:0] er, r;
        logic oth;
        int l;
        int a = int'(addr) & ~3;
        er = 0;
        if (we) for (int i = 0; i < 4; i++) ref_mem[a + i] = wdata[8*i +: 8];
        else    er = ref_word(a);
        dbg_xfer(we, addr, wdata, r, l, oth);
        check({tag, ".rdata"}, r, er);
        check({tag, ".lat"}, 32'(l), 32'd2);
        check({tag, ".cpu_ack"}, {31'b0, oth}, 32'h0);
        rdata = r;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},     {31'b0, bus.busy},    32'h0);
        check({tag, ".cpu_ack"},  {31'b0, bus.cpu_ack}, 32'h0);
        check({tag, ".cpu_err"},  {31'b0, bus.cpu_err}, 32'h0);
        check({tag, ".dbg_ack"},  {31'b0, bus.dbg_ack}, 32'h0);
        check({tag, ".mem_we"},   {31'b0, bus.mem_we},  32'h0);
        check({tag, ".mem_addr"}, 32'(bus.mem_addr),    32'h0);
        check({tag, ".mem_din"},  bus.mem_din,          32'h0);
        check({tag, ".cpu_rdata"}, bus.cpu_rdata,       32'h0);
        check({tag, ".dbg_rdata"}, bus.dbg_rdata,       32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int w0;
        int seq[$];

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_sext = 0;
        bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Word store then word load, one memory write.
        w0 = we_cnt;
        cpu_op("sw", 1, 2'b10, 0, 10'h010, 32'hDEADBEEF, rd);
        check("sw.we_pulses", 32'(we_cnt - w0), 32'd1);
        cpu_op("lw", 0, 2'b10, 0, 10'h010, 32'h0, rd);
        check("lw.const", rd, 32'hDEADBEEF);

        // Byte store by read-modify-write and byte loads.
        cpu_op("sb", 1, 2'b00, 0, 10'h011, 32'hFFFF_FF5A, rd);
        cpu_op("lw2", 0, 2'b10, 0, 10'h010, 32'h0, rd);
        check("lw2.const", rd, 32'hDEAD5AEF);
        cpu_op("lb", 0, 2'b00, 1, 10'h013, 32'h0, rd);
        check("lb.const", rd, 32'hFFFFFFDE);
        cpu_op("lbu", 0, 2'b00, 0, 10'h013, 32'h0, rd);
        check("lbu.const", rd, 32'h000000DE);

        // Half store and half loads.
        cpu_op("sh", 1, 2'b01, 0, 10'h012, 32'hABCD1234, rd);
        cpu_op("lw3", 0, 2'b10, 0, 10'h010, 32'h0, rd);
        check("lw3.const", rd, 32'h12345AEF);
        cpu_op("lhu", 0, 2'b01, 0, 10'h012, 32'h0, rd);
        check("lhu.const", rd, 32'h00001234);
        cpu_op("lh", 0, 2'b01, 1, 10'h010, 32'h0, rd);
        check("lh.const", rd, 32'h00005AEF);

        // Misaligned accesses: immediate error, no memory write.
        w0 = we_cnt;
        cpu_op("mis_lh", 0, 2'b01, 0, 10'h013, 32'h0, rd);
        cpu_op("mis_lw", 0, 2'b10, 0, 10'h012, 32'h0, rd);
        cpu_op("mis_sw", 1, 2'b11, 0, 10'h012, 32'h55555555, rd);
        check("mis.we_pulses", 32'(we_cnt - w0), 32'd0);

        // Both ports held high after reset: CPU, DBG, CPU, DBG.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.cpu_we = 0; bus.cpu_size = 2'b10; bus.cpu_sext = 0; bus.cpu_addr = 10'h010;
        bus.dbg_we = 0; bus.dbg_addr = 10'h022;
        bus.cpu_req = 1; bus.dbg_req = 1;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dbg_ack) begin
                check("rr.overlap", {31'b0, bus.cpu_ack & bus.dbg_ack}, 32'h0);
                check("rr.busy", {31'b0, bus.busy}, 32'h1);
                if (bus.cpu_ack) begin
                    seq.push_back(0);
                    check("rr.cpu_rdata", bus.cpu_rdata, ref_word(16'h010));
                end else begin
                    seq.push_back(1);
                    check("rr.dbg_rdata", bus.dbg_rdata, ref_word(16'h020));
                end
            end
        end
        bus.cpu_req = 0; bus.dbg_req = 0;
        check("rr.count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++) check("rr.order", 32'(seq[i]), 32'(i % 2));
        @(negedge clk);
        @(negedge clk);
        check("rr.idle_busy", {31'b0, bus.busy}, 32'h0);

        // Reset while the byte store sits in RMW_RD.
        @(negedge clk);
        bus.cpu_we = 1; bus.cpu_size = 2'b00; bus.cpu_addr = 10'h010;
        bus.cpu_wdata = 32'h000000C3; bus.cpu_req = 1;
        @(negedge clk);
        check("abort.busy", {31'b0, bus.busy}, 32'h1);
        check("abort.mem_addr", 32'(bus.mem_addr), 32'h010);
        check("abort.mem_we", {31'b0, bus.mem_we}, 32'h0);
        w0 = we_cnt;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        bus.cpu_req = 0;
        repeat (2) @(negedge clk);
        check("abort.no_ack", {31'b0, bus.cpu_ack}, 32'h0);
        rst_n = 1'b1;
        check("abort.we_pulses", 32'(we_cnt - w0), 32'd0);
        dbg_op("abort.rb", 0, 10'h010, 32'h0, rd);
        check("abort.rb.const", rd, 32'h12345AEF);

        // Random traffic from both ports, one request at a time.
        for (int n = 0; n < 80; n++) begin
            logic [9:0]  a  = 10'($urandom_range(0, 63));
            logic [31:0] wd = $urandom;
            logic        we = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                dbg_op("rnd_dbg", we, a, wd, rd);
            else
                cpu_op("rnd_cpu", we, 2'($urandom), 1'($urandom), a, wd, rd);
        end
        for (int a = 0; a < 64; a += 4) check("rnd.mem", mem[a / 4], ref_word(a));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
